// File: rtl/ov_accumulator.sv
// Signed running accumulator with per-add overflow pulse, sticky flag, saturating event
// counter and optional halt-on-overflow. Define OV_ACC_SATURATE_EN to clamp acc on overflow.
module ov_accumulator #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 4,
  parameter int HALT_ON_OV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] acc,
  output logic             out_valid,
  output logic             ov_pulse,
  output logic             ov_flag,
  output logic [CNT_W-1:0] ov_count,
  output logic             fault
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  localparam logic HALT_EN = (HALT_ON_OV != 32'sd0);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             fault_r;
  logic             in_ready_s;
  logic             accept_s;
  logic             ov_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] acc_r;
  logic             out_valid_r;
  logic             ov_pulse_r;
  logic             ov_flag_r;
  logic [CNT_W-1:0] ov_count_r;

  // Two operands of equal sign whose sum flips sign is the only overflow case.
  function automatic logic ov_detect(input logic a, input logic b, input logic s);
    return (a & b & ~s) | (~a & ~b & s);
  endfunction

  // Input handshake: only RUN accepts, and never in a clear cycle.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_RUN:   in_ready_s = ~clear;
      ST_FAULT: in_ready_s = 1'b0;
      default:  in_ready_s = 1'b0;
    endcase
  end

  // Adder, overflow decision and the value acc will take on accept.
  always_comb begin
    sum_s     = acc_r + in_data;
    ov_s      = ov_detect(acc_r[WIDTH-1], in_data[WIDTH-1], sum_s[WIDTH-1]);
    accept_s  = in_valid & in_ready_s;
    acc_nxt_s = sum_s;
`ifdef OV_ACC_SATURATE_EN
    // On overflow both operand signs agree, so acc's sign picks the clamp direction.
    if (ov_s) begin
      if (acc_r[WIDTH-1]) begin
        acc_nxt_s = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        acc_nxt_s = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      acc_nxt_s = sum_s;
    end
`endif
  end

  // FSM next state: clear always returns to RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (clear) begin
          state_nxt_s = ST_RUN;
        end else if (accept_s && ov_s && HALT_EN) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (clear) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // State register with a registered copy of the FAULT decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      fault_r <= (state_nxt_s == ST_FAULT);
    end
  end

  // Accumulator, result pulses, sticky flag and saturating event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= '0;
      out_valid_r <= 1'b0;
      ov_pulse_r  <= 1'b0;
      ov_flag_r   <= 1'b0;
      ov_count_r  <= '0;
    end else if (clear) begin
      acc_r       <= '0;
      out_valid_r <= 1'b0;
      ov_pulse_r  <= 1'b0;
      ov_flag_r   <= 1'b0;
      ov_count_r  <= '0;
    end else begin
      out_valid_r <= accept_s;
      ov_pulse_r  <= accept_s & ov_s;
      if (accept_s) begin
        acc_r <= acc_nxt_s;
      end
      if (accept_s && ov_s) begin
        ov_flag_r <= 1'b1;
        if (!(&ov_count_r)) begin
          ov_count_r <= ov_count_r + CNT_W'(1'b1);
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign acc       = acc_r;
  assign out_valid = out_valid_r;
  assign ov_pulse  = ov_pulse_r;
  assign ov_flag   = ov_flag_r;
  assign ov_count  = ov_count_r;
  assign fault     = fault_r;

endmodule

// File: tb/tb_ov_accumulator.sv
// Directed bench for ov_accumulator: instance 0 keeps running on overflow, instance 1 halts.
// Expected results come from an integer-range reference model pushed into a scoreboard queue.
module tb_ov_accumulator;

`ifdef OV_ACC_SATURATE_EN
  localparam logic [7:0] EXP_POS_OV = 8'h7F;
  localparam logic [7:0] EXP_NEG_OV = 8'h80;
  localparam logic [7:0] EXP_MIN_OV = 8'h80;
`else
  localparam logic [7:0] EXP_POS_OV = 8'h96;
  localparam logic [7:0] EXP_NEG_OV = 8'h6A;
  localparam logic [7:0] EXP_MIN_OV = 8'h00;
`endif

  typedef struct {
    int         sel;
    logic [7:0] acc;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear_v     [2];
  logic       valid_v     [2];
  logic [7:0] data_v      [2];
  logic       ready_v     [2];
  logic [7:0] acc_v       [2];
  logic       out_valid_v [2];
  logic       ov_pulse_v  [2];
  logic       ov_flag_v   [2];
  logic [3:0] ov_count_v  [2];
  logic       fault_v     [2];

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] m_acc   [2];
  logic       m_flag  [2];
  logic [3:0] m_cnt   [2];
  logic       m_fault [2];

  initial forever #5 clk = ~clk;

  ov_accumulator #(.WIDTH(8), .CNT_W(4), .HALT_ON_OV(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear_v[0]), .in_valid(valid_v[0]), .in_data(data_v[0]),
    .in_ready(ready_v[0]), .acc(acc_v[0]), .out_valid(out_valid_v[0]), .ov_pulse(ov_pulse_v[0]),
    .ov_flag(ov_flag_v[0]), .ov_count(ov_count_v[0]), .fault(fault_v[0])
  );

  ov_accumulator #(.WIDTH(8), .CNT_W(4), .HALT_ON_OV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear_v[1]), .in_valid(valid_v[1]), .in_data(data_v[1]),
    .in_ready(ready_v[1]), .acc(acc_v[1]), .out_valid(out_valid_v[1]), .ov_pulse(ov_pulse_v[1]),
    .ov_flag(ov_flag_v[1]), .ov_count(ov_count_v[1]), .fault(fault_v[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i]   = 8'h00;
      m_flag[i]  = 1'b0;
      m_cnt[i]   = 4'h0;
      m_fault[i] = 1'b0;
    end
  endtask

  task automatic drive_idle();
    for (int i = 0; i < 2; i++) begin
      clear_v[i] = 1'b0;
      valid_v[i] = 1'b0;
      data_v[i]  = 8'h00;
    end
  endtask

  // One cycle on instance sel: drive at negedge, check in_ready, update model, check after posedge.
  task automatic step(input int sel, input logic v, input logic [7:0] d, input logic clr);
    logic       exp_ready;
    logic       accepted;
    logic       ov;
    int         s;
    logic [7:0] nxt;
    exp_t       e;
    @(negedge clk);
    drive_idle();
    clear_v[sel] = clr;
    valid_v[sel] = v;
    data_v[sel]  = d;
    #1;
    exp_ready = !clr && !m_fault[sel];
    check("in_ready", ready_v[sel], exp_ready);
    accepted = v && exp_ready;
    if (clr) begin
      m_acc[sel]   = 8'h00;
      m_flag[sel]  = 1'b0;
      m_cnt[sel]   = 4'h0;
      m_fault[sel] = 1'b0;
    end else if (accepted) begin
      s   = int'($signed(m_acc[sel])) + int'($signed(d));
      ov  = (s > 127) || (s < -128);
      nxt = s[7:0];
`ifdef OV_ACC_SATURATE_EN
      if (ov) nxt = (s > 0) ? 8'h7F : 8'h80;
`endif
      m_acc[sel] = nxt;
      if (ov) begin
        m_flag[sel] = 1'b1;
        if (m_cnt[sel] != 4'hF) m_cnt[sel] = m_cnt[sel] + 4'h1;
        if (sel == 1) m_fault[sel] = 1'b1;
      end
      e.sel = sel;
      e.acc = nxt;
      e.ov  = ov;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid_v[sel], accepted);
    if (accepted) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 1'b0, 1'b1);
      end else begin
        e = sb.pop_front();
        check("acc", acc_v[e.sel], e.acc);
        check("ov_pulse", ov_pulse_v[e.sel], e.ov);
      end
    end else begin
      check("acc_hold", acc_v[sel], m_acc[sel]);
      check("ov_pulse_idle", ov_pulse_v[sel], 1'b0);
    end
    check("ov_flag", ov_flag_v[sel], m_flag[sel]);
    check("ov_count", ov_count_v[sel], m_cnt[sel]);
    check("fault", fault_v[sel], m_fault[sel]);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_acc", acc_v[i], 8'h00);
      check("rst_out_valid", out_valid_v[i], 1'b0);
      check("rst_ov_pulse", ov_pulse_v[i], 1'b0);
      check("rst_ov_flag", ov_flag_v[i], 1'b0);
      check("rst_ov_count", ov_count_v[i], 4'h0);
      check("rst_fault", fault_v[i], 1'b0);
    end
    rst_n = 1'b1;
    #1;
    check("rst_ready0", ready_v[0], 1'b1);
    check("rst_ready1", ready_v[1], 1'b1);

    // Plain accumulation, back to back.
    step(0, 1'b1, 8'd10, 1'b0);
    step(0, 1'b1, 8'd20, 1'b0);
    step(0, 1'b1, -8'sd5, 1'b0);
    check("acc_25", acc_v[0], 8'd25);
    step(0, 1'b1, 8'd0, 1'b0);
    step(0, 1'b1, -8'sd100, 1'b0);

    // Positive overflow without halting.
    step(0, 1'b0, 8'd0, 1'b1);
    step(0, 1'b1, 8'd100, 1'b0);
    step(0, 1'b1, 8'd50, 1'b0);
    check("pos_ov_acc", acc_v[0], EXP_POS_OV);
    check("pos_ov_count", ov_count_v[0], 4'h1);
    step(0, 1'b0, 8'd0, 1'b0);

    // Negative overflow with halt, held input ignored, then clear.
    step(1, 1'b1, -8'sd100, 1'b0);
    step(1, 1'b1, -8'sd50, 1'b0);
    check("neg_ov_acc", acc_v[1], EXP_NEG_OV);
    check("neg_ov_fault", fault_v[1], 1'b1);
    repeat (4) step(1, 1'b1, 8'd5, 1'b0);
    check("halt_acc", acc_v[1], EXP_NEG_OV);
    step(1, 1'b1, 8'd5, 1'b1);
    step(1, 1'b0, 8'd0, 1'b0);
    check("clr_acc", acc_v[1], 8'h00);
    step(1, 1'b1, 8'd3, 1'b0);

    // Most-negative plus most-negative.
    step(0, 1'b0, 8'd0, 1'b1);
    step(0, 1'b1, 8'h80, 1'b0);
    step(0, 1'b1, 8'h80, 1'b0);
    check("min_ov_acc", acc_v[0], EXP_MIN_OV);
    check("min_ov_pulse", ov_pulse_v[0], 1'b1);

    // Seventeen overflow events: counter saturates, pulses continue.
    step(0, 1'b0, 8'd0, 1'b1);
    step(0, 1'b1, 8'd100, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1'b1, m_acc[0][7] ? 8'h80 : 8'h7F, 1'b0);
      check("sat_pulse", ov_pulse_v[0], 1'b1);
    end
    check("sat_count", ov_count_v[0], 4'hF);
    check("sat_flag", ov_flag_v[0], 1'b1);

    // Asynchronous reset during an accept cycle.
    step(0, 1'b0, 8'd0, 1'b1);
    step(0, 1'b1, 8'd40, 1'b0);
    @(negedge clk);
    valid_v[0] = 1'b1;
    data_v[0]  = 8'd5;
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc", acc_v[0], 8'h00);
    check("arst_out_valid", out_valid_v[0], 1'b0);
    check("arst_ov_pulse", ov_pulse_v[0], 1'b0);
    check("arst_ov_flag", ov_flag_v[0], 1'b0);
    check("arst_ov_count", ov_count_v[0], 4'h0);
    check("arst_acc1", acc_v[1], 8'h00);
    @(posedge clk);
    #1;
    check("arst_hold_acc", acc_v[0], 8'h00);
    check("arst_hold_valid", out_valid_v[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    model_reset();
    sb.delete();
    step(0, 1'b0, 8'd0, 1'b0);
    step(0, 1'b1, 8'd7, 1'b0);
    check("post_rst_acc", acc_v[0], 8'd7);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
